// File: rtl/coin_input_cond.sv
// Coin/button input conditioner: 2-flop sync, debounce, rising-edge detect and lockout
// arbitration into one-hot b1/b2/b3 pulses. Define COIN_COUNT_EN to add coin_count.
module coin_input_cond #(
  parameter int DEB_CYCLES = 4,
  parameter int LOCKOUT    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        raw_b1,
  input  logic        raw_b2,
  input  logic        raw_b3,
  output logic        b1,
  output logic        b2,
  output logic        b3,
  output logic        coin_reject,
  output logic        busy,
  output logic        pending
`ifdef COIN_COUNT_EN
  ,
  output logic [15:0] coin_count
`endif
);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);
  // Counter spans LOCKOUT suppressed cycles, so pulses land LOCKOUT+1 clocks apart.
  localparam logic [7:0] LOCK_LOAD = 8'(LOCKOUT);

  logic [2:0] w_raw;
  logic [2:0] r_sync1, r_sync2, r_stable, r_stable_d;
  logic [7:0] r_deb_cnt [3];

  assign w_raw = {raw_b3, raw_b2, raw_b1};

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable_d <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
    end
  end

  // NOTE: the debounce counter array is tiny state, not storage, so it is reset like any flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stable <= '0;
      for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] != r_stable[i]) begin
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_stable[i]  <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 8'd1;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  logic [2:0] w_evt;
  logic       w_multi;
  logic       w_cand;
  logic [1:0] w_cand_code;

  assign w_evt   = r_stable & ~r_stable_d;
  assign w_multi = (w_evt & (w_evt - 3'd1)) != 3'd0;
  assign w_cand  = (w_evt != 3'd0) && !w_multi;

  always_comb begin
    w_cand_code = 2'd0;
    case (w_evt)
      3'b001:  w_cand_code = 2'd1;
      3'b010:  w_cand_code = 2'd2;
      3'b100:  w_cand_code = 2'd3;
      default: w_cand_code = 2'd0;
    endcase
  end

  function automatic logic [2:0] code_to_onehot(input logic [1:0] code);
    case (code)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  state_t     r_state, w_state_nx;
  logic [7:0] r_lock_cnt, w_lock_nx;
  logic       r_pend_valid, w_pend_valid_nx;
  logic [1:0] r_pend_code, w_pend_code_nx;
  logic [2:0] r_b, w_b_nx;
  logic       r_reject, w_reject_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_lock_cnt   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_code  <= '0;
      r_b          <= '0;
      r_reject     <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_lock_cnt   <= w_lock_nx;
      r_pend_valid <= w_pend_valid_nx;
      r_pend_code  <= w_pend_code_nx;
      r_b          <= w_b_nx;
      r_reject     <= w_reject_nx;
    end
  end

  // NOTE: every output of this block is given a default first so no path can infer a latch.
  always_comb begin
    w_state_nx      = r_state;
    w_lock_nx       = r_lock_cnt;
    w_pend_valid_nx = r_pend_valid;
    w_pend_code_nx  = r_pend_code;
    w_b_nx          = '0;
    w_reject_nx     = w_multi;
    case (r_state)
      S_IDLE: begin
        if (w_cand) begin
          w_b_nx     = w_evt;
          w_lock_nx  = LOCK_LOAD;
          w_state_nx = S_LOCK;
        end
      end
      S_LOCK: begin
        if (r_lock_cnt != 8'd0) begin
          w_lock_nx = r_lock_cnt - 8'd1;
          if (w_cand) begin
            if (!r_pend_valid) begin
              w_pend_valid_nx = 1'b1;
              w_pend_code_nx  = w_cand_code;
            end else begin
              w_reject_nx = 1'b1;
            end
          end
        end else if (r_pend_valid) begin
          // Release the buffered coin; a same-cycle candidate takes the freed slot.
          w_b_nx          = code_to_onehot(r_pend_code);
          w_lock_nx       = LOCK_LOAD;
          w_pend_valid_nx = w_cand;
          w_pend_code_nx  = w_cand_code;
        end else if (w_cand) begin
          w_b_nx    = w_evt;
          w_lock_nx = LOCK_LOAD;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  assign b1          = r_b[0];
  assign b2          = r_b[1];
  assign b3          = r_b[2];
  assign coin_reject = r_reject;
  assign pending     = r_pend_valid;
  assign busy        = (r_state == S_LOCK) | r_pend_valid;

`ifdef COIN_COUNT_EN
  logic [15:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if ((w_b_nx != 3'd0) && (r_count != 16'hFFFF)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign coin_count = r_count;
`endif

endmodule
